instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - streams a length-prefixed program into instruction memory, holds the CPU in reset until loaded
module instruction_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [63:0] ADDR_BASE = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          IW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [31:0] MAX_W = MAX_WORDS;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERROR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     count;
    logic [1:0]      byte_cnt;
    logic [IW-1:0]   word_index;
    logic [23:0]     partial;
    logic            transfer;
    logic            len_ok;
    logic            last_word;
    logic            restart;

    assign transfer  = rx_valid & rx_ready;
    assign len_ok    = ({rx_data, count[7:0]} != 16'd0) &&
                       ({16'd0, rx_data, count[7:0]} <= MAX_W);
    assign last_word = (32'(word_index) == (32'(count) - 32'd1));
    assign restart   = start && (state == IDLE || state == DONE || state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LEN_LO;
            LEN_LO:  if (transfer) state_next = LEN_HI;
            LEN_HI:  if (transfer) state_next = len_ok ? DATA : ERROR;
            DATA:    if (transfer && byte_cnt == 2'd3 && last_word) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    if (start) state_next = LEN_LO;
            ERROR:   if (start) state_next = LEN_LO;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_ready  = 1'b0;
        busy      = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            FLUSH: busy = 1'b1;
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    // Write port is registered: the strobe lands the cycle after a word's last byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 16'd0;
            byte_cnt   <= 2'd0;
            word_index <= '0;
            partial    <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 64'd0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                byte_cnt   <= 2'd0;
                word_index <= '0;
                partial    <= 24'd0;
            end
            if (transfer) begin
                case (state)
                    LEN_LO: count[7:0]  <= rx_data;
                    LEN_HI: count[15:8] <= rx_data;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: partial[7:0]   <= rx_data;
                            2'd1: partial[15:8]  <= rx_data;
                            2'd2: partial[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, partial};
                                imem_addr  <= ADDR_BASE + (64'(word_index) << 2);
                                // Holding the index on the final word keeps it in range.
                                if (!last_word) word_index <= word_index + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
